pipe_stall_ctrl: RTL and testbench

- Consumer of the hazard-detect stall requests. Turns load_stall, br_stall[1:0], the EX-stage branch mispredict and an external memory freeze into per-stage write-enable, flush and bubble controls for the 5-stage core.
- Owns pcsrc_counter, the post-redirect instruction counter that hazard detection uses to suppress stalls while the pipe holds stale slots.
- Sits between the hazard unit, the branch-resolve logic and the PC, IF/ID and ID/EX registers.

---
 rtl/pipe_stall_ctrl_if.sv | 48 ++++
 rtl/pipe_stall_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - stall/flush control bundle between hazard, branch-resolve and pipeline registers
//
// Signals:
//   load_stall, br_stall[1:0], mispredict, ext_stall : stall/redirect requests into the controller
//   pc_write, ifid_write, ifid_flush, idex_write, idex_flush : per-stage controls out of the controller
//   pcsrc_counter[2:0] : instructions fetched since the last redirect, saturating
//   perf_stall_cyc, perf_flush_cnt, perf_ext_cyc : event counters (only with STALL_PERF_EN)
// Modports: master = request/consumer side, slave = pipe_stall_ctrl.

interface pipe_stall_ctrl_if;
    logic        load_stall;
    logic [1:0]  br_stall;
    logic        mispredict;
    logic        ext_stall;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_write;
    logic        idex_flush;
    logic [2:0]  pcsrc_counter;
`ifdef STALL_PERF_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_ext_cyc;

    modport master (
        output load_stall, br_stall, mispredict, ext_stall,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush, pcsrc_counter,
        input  perf_stall_cyc, perf_flush_cnt, perf_ext_cyc
    );

    modport slave (
        input  load_stall, br_stall, mispredict, ext_stall,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_flush, pcsrc_counter,
        output perf_stall_cyc, perf_flush_cnt, perf_ext_cyc
    );
`else
    modport master (
        output load_stall, br_stall, mispredict, ext_stall,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush, pcsrc_counter
    );

    modport slave (
        input  load_stall, br_stall, mispredict, ext_stall,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_flush, pcsrc_counter
    );
`endif
endinterface

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush controller with post-redirect fetch counter
//
// Turns hazard stall requests, EX mispredict and the external memory freeze into
// PC / IF/ID / ID/EX enables, flushes and bubbles. Controls are combinational;
// state, hold count and pcsrc_counter update on the rising edge.
//
// Ports:
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pipe_stall_ctrl_if.slave (requests in, stage controls and counters out)
// Parameters:
//   CNT_SAT    : pcsrc_counter saturation value (2..7)
//   LDBR_STALL : total bubbles for a load feeding an ID branch (2..3)
// Optional: define STALL_PERF_EN to add the 32-bit perf counters.

module pipe_stall_ctrl #(
    parameter int unsigned CNT_SAT    = 7,
    parameter int unsigned LDBR_STALL = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_stall_ctrl_if.slave     bus
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [2:0] CNT_MAX   = 3'(CNT_SAT);
    // First bubble is issued from RUN, so HOLD covers only the remaining ones.
    localparam logic [1:0] HOLD_INIT = 2'(LDBR_STALL - 1);

    logic [0:0] state, state_nxt;
    logic [1:0] hold_cnt, hold_cnt_nxt;
    logic [2:0] cnt, cnt_nxt;

    logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush;

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_flush   = 1'b0;
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;

        if (bus.ext_stall) begin
            // Whole front end frozen; a mispredict stays asserted in the frozen EX.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
        end else if (bus.mispredict) begin
            // Redirect squashes the stalled branch, so any pending HOLD is dropped.
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            state_nxt    = ST_RUN;
            hold_cnt_nxt = 2'd0;
        end else if (state == ST_HOLD) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_flush   = 1'b1;
            hold_cnt_nxt = hold_cnt - 2'd1;
            if (hold_cnt <= 2'd1) begin
                state_nxt    = ST_RUN;
                hold_cnt_nxt = 2'd0;
            end
        end else if (bus.load_stall || (bus.br_stall != 2'b00)) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            if (bus.br_stall[1]) begin
                state_nxt    = ST_HOLD;
                hold_cnt_nxt = HOLD_INIT;
            end
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if (bus.ext_stall) begin
            cnt_nxt = cnt;
        end else if (bus.mispredict) begin
            cnt_nxt = 3'd0;
        end else if (pc_write && (cnt < CNT_MAX)) begin
            cnt_nxt = cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            hold_cnt <= 2'd0;
            cnt      <= 3'd0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            cnt      <= cnt_nxt;
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.ifid_write    = ifid_write;
    assign bus.ifid_flush    = ifid_flush;
    assign bus.idex_write    = idex_write;
    assign bus.idex_flush    = idex_flush;
    assign bus.pcsrc_counter = cnt;

`ifdef STALL_PERF_EN
    logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_ext_cyc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cyc <= 32'd0;
            perf_flush_cnt <= 32'd0;
            perf_ext_cyc   <= 32'd0;
        end else begin
            if (!pc_write && !bus.ext_stall) perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (bus.mispredict && !bus.ext_stall) perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if (bus.ext_stall) perf_ext_cyc <= perf_ext_cyc + 32'd1;
        end
    end

    assign bus.perf_stall_cyc = perf_stall_cyc;
    assign bus.perf_flush_cnt = perf_flush_cnt;
    assign bus.perf_ext_cyc   = perf_ext_cyc;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - table-driven and sequence checks for pipe_stall_ctrl

`timescale 1ns/1ps

module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if ifa ();
    pipe_stall_ctrl_if ifb ();

    // Second instance (LDBR_STALL=3) sees the same requests as the first.
    assign ifb.load_stall = ifa.load_stall;
    assign ifb.br_stall   = ifa.br_stall;
    assign ifb.mispredict = ifa.mispredict;
    assign ifb.ext_stall  = ifa.ext_stall;

    pipe_stall_ctrl #(.CNT_SAT(7), .LDBR_STALL(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    pipe_stall_ctrl #(.CNT_SAT(7), .LDBR_STALL(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush}
    localparam logic [4:0] C_RUN    = 5'b11010;
    localparam logic [4:0] C_STALL  = 5'b00011;
    localparam logic [4:0] C_FLUSH  = 5'b11111;
    localparam logic [4:0] C_FREEZE = 5'b00000;

    typedef struct {
        logic       load;
        logic [1:0] br;
        logic       mis;
        logic       ext;
        logic [4:0] exp_ctl;
        logic [2:0] exp_cnt;
    } vec_t;

    vec_t vecs[27];

    int checks = 0;
    int failures = 0;

    function automatic logic [4:0] ctl_a();
        return {ifa.pc_write, ifa.ifid_write, ifa.ifid_flush, ifa.idex_write, ifa.idex_flush};
    endfunction

    function automatic logic [4:0] ctl_b();
        return {ifb.pc_write, ifb.ifid_write, ifb.ifid_flush, ifb.idex_write, ifb.idex_flush};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic load, input logic [1:0] br, input logic mis, input logic ext);
        ifa.load_stall = load;
        ifa.br_stall   = br;
        ifa.mispredict = mis;
        ifa.ext_stall  = ext;
    endtask

    // Leaves the bench at a falling edge with reset just released.
    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one cycle at the current falling edge, check A, advance to next falling edge.
    task automatic step_a(input string name, input logic load, input logic [1:0] br,
                          input logic mis, input logic ext,
                          input logic [4:0] exp_ctl, input logic [2:0] exp_cnt);
        drive(load, br, mis, ext);
        #1;
        chk({name, "_ctl"}, 32'(ctl_a()), 32'(exp_ctl));
        chk({name, "_cnt"}, 32'(ifa.pcsrc_counter), 32'(exp_cnt));
        @(negedge clk);
    endtask

    initial begin
        drive(1'b0, 2'b00, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++)
            vecs[i] = '{1'b0, 2'b00, 1'b0, 1'b0, C_RUN, (i < 7) ? 3'(i) : 3'd7};
        vecs[10] = '{1'b0, 2'b00, 1'b1, 1'b0, C_FLUSH,  3'd7};
        vecs[11] = '{1'b0, 2'b00, 1'b0, 1'b0, C_RUN,    3'd0};
        vecs[12] = '{1'b1, 2'b00, 1'b0, 1'b0, C_STALL,  3'd1};
        vecs[13] = '{1'b0, 2'b00, 1'b0, 1'b0, C_RUN,    3'd1};
        vecs[14] = '{1'b0, 2'b01, 1'b0, 1'b0, C_STALL,  3'd2};
        vecs[15] = '{1'b0, 2'b00, 1'b0, 1'b0, C_RUN,    3'd2};
        vecs[16] = '{1'b0, 2'b10, 1'b0, 1'b0, C_STALL,  3'd3};
        vecs[17] = '{1'b1, 2'b00, 1'b0, 1'b0, C_STALL,  3'd3};
        vecs[18] = '{1'b0, 2'b00, 1'b0, 1'b0, C_RUN,    3'd3};
        vecs[19] = '{1'b0, 2'b11, 1'b0, 1'b0, C_STALL,  3'd4};
        vecs[20] = '{1'b0, 2'b00, 1'b0, 1'b0, C_STALL,  3'd4};
        vecs[21] = '{1'b0, 2'b00, 1'b0, 1'b0, C_RUN,    3'd4};
        vecs[22] = '{1'b0, 2'b10, 1'b1, 1'b0, C_FLUSH,  3'd5};
        vecs[23] = '{1'b0, 2'b00, 1'b0, 1'b0, C_RUN,    3'd0};
        vecs[24] = '{1'b1, 2'b00, 1'b0, 1'b1, C_FREEZE, 3'd1};
        vecs[25] = '{1'b0, 2'b00, 1'b1, 1'b1, C_FREEZE, 3'd1};
        vecs[26] = '{1'b0, 2'b00, 1'b0, 1'b0, C_RUN,    3'd1};

        // Reset values while rst_n is held low
        @(negedge clk);
        #1;
        chk("reset_ctl_a", 32'(ctl_a()), 32'(C_RUN));
        chk("reset_cnt_a", 32'(ifa.pcsrc_counter), 32'd0);
        chk("reset_ctl_b", 32'(ctl_b()), 32'(C_RUN));

        // Table: reset release, saturation, 1-cycle stalls, HOLD, mispredict, freeze
        do_reset();
        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].load, vecs[i].br, vecs[i].mis, vecs[i].ext);
            #1;
            chk($sformatf("vec%0d_ctl", i), 32'(ctl_a()), 32'(vecs[i].exp_ctl));
            chk($sformatf("vec%0d_cnt", i), 32'(ifa.pcsrc_counter), 32'(vecs[i].exp_cnt));
            @(negedge clk);
        end

        // Load feeding branch: 2 bubbles (A) vs 3 bubbles (B); load pulse in bubble 2 adds none
        do_reset();
        drive(1'b0, 2'b10, 1'b0, 1'b0); #1;
        chk("ldbr_c0_a", 32'(ctl_a()), 32'(C_STALL));
        chk("ldbr_c0_b", 32'(ctl_b()), 32'(C_STALL));
        @(negedge clk);
        drive(1'b1, 2'b00, 1'b0, 1'b0); #1;
        chk("ldbr_c1_a", 32'(ctl_a()), 32'(C_STALL));
        chk("ldbr_c1_b", 32'(ctl_b()), 32'(C_STALL));
        @(negedge clk);
        drive(1'b0, 2'b00, 1'b0, 1'b0); #1;
        chk("ldbr_c2_a", 32'(ctl_a()), 32'(C_RUN));
        chk("ldbr_c2_b", 32'(ctl_b()), 32'(C_STALL));
        @(negedge clk);
        #1;
        chk("ldbr_c3_a", 32'(ctl_a()), 32'(C_RUN));
        chk("ldbr_c3_b", 32'(ctl_b()), 32'(C_RUN));
        chk("ldbr_c3_cnt", 32'(ifa.pcsrc_counter), 32'd1);
        @(negedge clk);

        // br_stall[1] then mispredict next cycle: flush wins, HOLD cancelled
        do_reset();
        step_a("brmis_c0", 1'b0, 2'b00, 1'b0, 1'b0, C_RUN,   3'd0);
        step_a("brmis_c1", 1'b0, 2'b10, 1'b0, 1'b0, C_STALL, 3'd1);
        step_a("brmis_c2", 1'b0, 2'b00, 1'b1, 1'b0, C_FLUSH, 3'd1);
        step_a("brmis_c3", 1'b0, 2'b00, 1'b0, 1'b0, C_RUN,   3'd0);

        // Freeze during HOLD with mispredict pending; flush lands once freeze drops
        do_reset();
        step_a("frz_c0", 1'b0, 2'b00, 1'b0, 1'b0, C_RUN,    3'd0);
        step_a("frz_c1", 1'b0, 2'b00, 1'b0, 1'b0, C_RUN,    3'd1);
        step_a("frz_c2", 1'b0, 2'b10, 1'b0, 1'b0, C_STALL,  3'd2);
        step_a("frz_c3", 1'b0, 2'b00, 1'b1, 1'b1, C_FREEZE, 3'd2);
        step_a("frz_c4", 1'b0, 2'b00, 1'b1, 1'b1, C_FREEZE, 3'd2);
        step_a("frz_c5", 1'b0, 2'b00, 1'b1, 1'b1, C_FREEZE, 3'd2);
        step_a("frz_c6", 1'b0, 2'b00, 1'b1, 1'b0, C_FLUSH,  3'd2);
        step_a("frz_c7", 1'b0, 2'b00, 1'b0, 1'b0, C_RUN,    3'd0);

        // Asynchronous reset in the middle of HOLD
        do_reset();
        step_a("rhold_c0", 1'b0, 2'b00, 1'b0, 1'b0, C_RUN,   3'd0);
        step_a("rhold_c1", 1'b0, 2'b00, 1'b0, 1'b0, C_RUN,   3'd1);
        step_a("rhold_c2", 1'b0, 2'b10, 1'b0, 1'b0, C_STALL, 3'd2);
        drive(1'b0, 2'b00, 1'b0, 1'b0); #1;
        chk("rhold_in_hold", 32'(ctl_a()), 32'(C_STALL));
        rst_n = 1'b0; #1;
        chk("rhold_async_ctl", 32'(ctl_a()), 32'(C_RUN));
        chk("rhold_async_cnt", 32'(ifa.pcsrc_counter), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef STALL_PERF_EN
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b00, 1'b0, 1'b0); @(negedge clk);
            drive(1'b0, 2'b00, 1'b0, 1'b0); @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 2'b00, 1'b1, 1'b0); @(negedge clk);
            drive(1'b0, 2'b00, 1'b0, 1'b0); @(negedge clk);
        end
        drive(1'b0, 2'b00, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        drive(1'b0, 2'b00, 1'b0, 1'b0); #1;
        chk("perf_stall", ifa.perf_stall_cyc, 32'd5);
        chk("perf_flush", ifa.perf_flush_cnt, 32'd2);
        chk("perf_ext",   ifa.perf_ext_cyc,   32'd4);
        rst_n = 1'b0; #1;
        chk("perf_stall_rst", ifa.perf_stall_cyc, 32'd0);
        chk("perf_flush_rst", ifa.perf_flush_cnt, 32'd0);
        chk("perf_ext_rst",   ifa.perf_ext_cyc,   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
